// File: rtl/spi_peripheral_if.sv
// rtl/spi_peripheral_if.sv - SPI pin bundle shared by controller and peripheral
interface spi_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;

    modport master (output sclk, output copi, output ncs, input cipo);
    modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - SPI mode-0 register peripheral, five 8-bit write registers
// Optional macro SPI_READBACK_EN serves read frames on cipo.
module spi_peripheral (
    input  logic                   clk,
    input  logic                   rst,
    spi_peripheral_if.slave        spi,
    output logic [7:0]             en_reg_out_7_0,
    output logic [7:0]             en_reg_out_15_8,
    output logic [7:0]             en_reg_pwm_7_0,
    output logic [7:0]             en_reg_pwm_15_8,
    output logic [7:0]             pwm_duty_cycle
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t      state, state_next;
    logic [1:0]  sclk_sync, copi_sync, ncs_sync;
    logic        sclk_prev, ncs_prev;
    logic        sclk_s, copi_s, ncs_s;
    logic        sclk_rise, ncs_rise, ncs_fall;
    logic [1:0]  settle;
    logic        armed;
    logic [15:0] shift_reg;
    logic [4:0]  bit_cnt;
    logic        commit_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 2'b00;
            copi_sync <= 2'b00;
            ncs_sync  <= 2'b11;
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], spi.sclk};
            copi_sync <= {copi_sync[0], spi.copi};
            ncs_sync  <= {ncs_sync[0], spi.ncs};
            sclk_prev <= sclk_sync[1];
            ncs_prev  <= ncs_sync[1];
        end
    end

    assign sclk_s    = sclk_sync[1];
    assign copi_s    = copi_sync[1];
    assign ncs_s     = ncs_sync[1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign ncs_rise  = ncs_s & ~ncs_prev;
    assign ncs_fall  = ~ncs_s & ncs_prev & armed;

    // After reset, a frame may only start once ncs has really been seen high at the
    // pin; otherwise a reset released mid-frame would look like a fresh falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle <= 2'b00;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[0], 1'b1};
            if (settle[1] && ncs_s)
                armed <= 1'b1;
        end
    end

    assign commit_ok = (bit_cnt == 5'd16) && shift_reg[15] && (shift_reg[14:8] <= 7'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ncs_fall) state_next = SHIFT;
            SHIFT:   if (ncs_rise) state_next = commit_ok ? COMMIT : IDLE;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= 16'h0000;
            bit_cnt   <= 5'd0;
        end else if (state == IDLE && ncs_fall) begin
            shift_reg <= 16'h0000;
            bit_cnt   <= 5'd0;
        end else if (state == SHIFT && sclk_rise && !ncs_s) begin
            shift_reg <= {shift_reg[14:0], copi_s};
            if (bit_cnt != 5'd17)
                bit_cnt <= bit_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else if (state == COMMIT) begin
            case (shift_reg[14:8])
                7'd0:    en_reg_out_7_0  <= shift_reg[7:0];
                7'd1:    en_reg_out_15_8 <= shift_reg[7:0];
                7'd2:    en_reg_pwm_7_0  <= shift_reg[7:0];
                7'd3:    en_reg_pwm_15_8 <= shift_reg[7:0];
                7'd4:    pwm_duty_cycle  <= shift_reg[7:0];
                default: ;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic [7:0] rd_data;
    logic [6:0] tx_shift;
    logic       cipo_q;

    assign sclk_fall = ~sclk_s & sclk_prev;

    // After eight bits the low byte of shift_reg holds {R/W, address}.
    always_comb begin
        rd_data = 8'h00;
        case (shift_reg[6:0])
            7'd0:    rd_data = en_reg_out_7_0;
            7'd1:    rd_data = en_reg_out_15_8;
            7'd2:    rd_data = en_reg_pwm_7_0;
            7'd3:    rd_data = en_reg_pwm_15_8;
            7'd4:    rd_data = pwm_duty_cycle;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cipo_q   <= 1'b0;
            tx_shift <= 7'd0;
        end else if (state != SHIFT || ncs_s) begin
            cipo_q   <= 1'b0;
            tx_shift <= 7'd0;
        end else if (sclk_fall) begin
            if (bit_cnt == 5'd8) begin
                {cipo_q, tx_shift} <= shift_reg[7] ? 8'h00 : rd_data;
            end else if (bit_cnt > 5'd8 && bit_cnt < 5'd16) begin
                cipo_q   <= tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
            end
        end
    end

    assign spi.cipo = cipo_q & ~spi.ncs;
`else
    assign spi.cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// tb/tb_spi_peripheral.sv - scoreboard bench for spi_peripheral register writes and readback
module tb_spi_peripheral;

    logic clk;
    logic rst;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

    spi_peripheral_if bus ();

    spi_peripheral dut (
        .clk             (clk),
        .rst             (rst),
        .spi             (bus),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  m_regs [5];
    logic [39:0] exp_q [$];
    logic [7:0]  rd_q [$];
    logic [7:0]  rx_byte;
    int          rise_cnt;

    function automatic logic [39:0] model_pack();
        return {m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    function automatic logic [39:0] dut_pack();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    task automatic half_sclk();
        repeat (8) @(negedge clk);
    endtask

    // Bits hi..lo of data, MSB first; cipo is sampled just before rises 9..16.
    task automatic drive_bits(input logic [31:0] data, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            bus.copi = data[i];
            half_sclk();
            if (rise_cnt >= 8 && rise_cnt < 16)
                rx_byte = {rx_byte[6:0], bus.cipo};
            bus.sclk = 1'b1;
            rise_cnt++;
            half_sclk();
            bus.sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] data, input int nbits);
        if (nbits == 16 && data[15] && data[14:8] <= 7'd4)
            m_regs[data[10:8]] = data[7:0];
        exp_q.push_back(model_pack());
        rx_byte  = 8'h00;
        rise_cnt = 0;
        bus.ncs  = 1'b0;
        half_sclk();
        drive_bits(data, nbits - 1, 0);
        half_sclk();
        bus.copi = 1'b0;
        bus.ncs  = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] got;
        rst = 1'b1;
        bus.ncs = 1'b1; bus.sclk = 1'b0; bus.copi = 1'b0;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        repeat (3) @(negedge clk);
        got = dut_pack();
        n_checks++;
        if (got !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h expected %h", got, 40'h0);
        end
        n_checks++;
        if (bus.cipo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cipo: got %b expected 0", bus.cipo);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_basic();
        logic [39:0] exp, got;
        send_frame(32'h80F0, 16);
        exp = exp_q.pop_front();
        got = dut_pack();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL write_80F0: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_write_sequence();
        logic [39:0] exp, got;
        logic [31:0] frames [2];
        frames[0] = 32'h8480;
        frames[1] = 32'h83FF;
        for (int f = 0; f < 2; f++) begin
            send_frame(frames[f], 16);
            exp = exp_q.pop_front();
            got = dut_pack();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL write_seq_%h: got %h expected %h", frames[f][15:0], got, exp);
            end
        end
        n_checks++;
        if (pwm_duty_cycle !== 8'h80) begin
            n_fail++;
            $display("FAIL duty_kept: got %h expected 80", pwm_duty_cycle);
        end
    endtask

    task automatic test_discard();
        logic [39:0] exp, got;
        logic [31:0] frames [2];
        frames[0] = 32'hB0AA;
        frames[1] = 32'h00AA;
        for (int f = 0; f < 2; f++) begin
            send_frame(frames[f], 16);
            exp = exp_q.pop_front();
            got = dut_pack();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL discard_%h: got %h expected %h", frames[f][15:0], got, exp);
            end
        end
    endtask

    task automatic test_frame_length();
        logic [39:0] exp, got;
        logic [31:0] frames [3];
        int          lens [3];
        frames[0] = 32'h080F;  lens[0] = 12;
        frames[1] = 32'h180F0; lens[1] = 17;
        frames[2] = 32'h8155;  lens[2] = 16;
        for (int f = 0; f < 3; f++) begin
            send_frame(frames[f], lens[f]);
            exp = exp_q.pop_front();
            got = dut_pack();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL length_%0d_bits: got %h expected %h", lens[f], got, exp);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [39:0] exp, got;
        rise_cnt = 0;
        bus.ncs  = 1'b0;
        half_sclk();
        drive_bits(32'h82AA, 15, 8);
        pulse_reset();
        exp_q.push_back(model_pack());
        drive_bits(32'h82AA, 7, 0);
        half_sclk();
        bus.copi = 1'b0;
        bus.ncs  = 1'b1;
        repeat (4) @(negedge clk);
        exp = exp_q.pop_front();
        got = dut_pack();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_midframe: got %h expected %h", got, exp);
        end
        repeat (4) @(negedge clk);
        send_frame(32'h82AA, 16);
        exp = exp_q.pop_front();
        got = dut_pack();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL after_reset_82AA: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_readback();
        logic [39:0] exp, got;
        logic [7:0]  rexp;
        logic [15:0] rd_frames [2];
        send_frame(32'h845A, 16);
        exp = exp_q.pop_front();
        got = dut_pack();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL write_845A: got %h expected %h", got, exp);
        end
        rd_frames[0] = 16'h0400;
        rd_frames[1] = 16'h0700;
        for (int f = 0; f < 2; f++) begin
`ifdef SPI_READBACK_EN
            rd_q.push_back(rd_frames[f][14:8] <= 7'd4 ? m_regs[rd_frames[f][10:8]] : 8'h00);
`else
            rd_q.push_back(8'h00);
`endif
            send_frame({16'h0, rd_frames[f]}, 16);
            exp  = exp_q.pop_front();
            rexp = rd_q.pop_front();
            n_checks++;
            if (rx_byte !== rexp) begin
                n_fail++;
                $display("FAIL readback_%h: got %h expected %h", rd_frames[f], rx_byte, rexp);
            end
            got = dut_pack();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL read_no_write_%h: got %h expected %h", rd_frames[f], got, exp);
            end
            n_checks++;
            if (bus.cipo !== 1'b0) begin
                n_fail++;
                $display("FAIL cipo_idle: got %b expected 0", bus.cipo);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ncs = 1'b1; bus.sclk = 1'b0; bus.copi = 1'b0;
        test_reset();
        test_write_basic();
        test_write_sequence();
        test_discard();
        test_frame_length();
        test_reset_midframe();
        test_readback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state is updated on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port sclk, input, 1 bit: SPI clock, asynchronous to clk.
REQ-004 SHALL have port copi, input, 1 bit: SPI controller-out data, asynchronous.
REQ-005 SHALL have port ncs, input, 1 bit: SPI chip select, active-low, asynchronous.
REQ-006 SHALL have port cipo, output, 1 bit: SPI controller-in data.
REQ-007 SHALL have port en_reg_out_7_0, output, 8 bits: output-enable register, address 0x00.
REQ-008 SHALL have port en_reg_out_15_8, output, 8 bits: output-enable register, address 0x01.
REQ-009 SHALL have port en_reg_pwm_7_0, output, 8 bits: PWM-enable register, address 0x02.
REQ-010 SHALL have port en_reg_pwm_15_8, output, 8 bits: PWM-enable register, address 0x03.
REQ-011 SHALL have port pwm_duty_cycle, output, 8 bits: duty-cycle register, address 0x04.

Function
REQ-012 SHALL pass sclk, copi and ncs each through a two-flop synchronizer into the clk domain.
REQ-013 SHALL detect sclk rising/falling edges and ncs rising/falling edges from the synchronized signals.
REQ-014 SHALL implement SPI mode 0: copi sampled on sclk rising edge, MSB first, only while synchronized ncs is low.
REQ-015 SHALL use a 16-bit frame: bit15 R/W (1=write, 0=read); bits14:8 address (7 bits); bits7:0 data.
REQ-016 SHALL implement FSM states IDLE, SHIFT and COMMIT.
REQ-017 SHALL transition IDLE->SHIFT on the ncs falling edge, clearing the shift register and bit counter.
REQ-018 SHALL, in SHIFT, increment the bit counter per sclk rising edge, saturating at 17.
REQ-019 SHALL, in SHIFT on the ncs rising edge, go to COMMIT if counter==16, R/W==1 and address<=0x04; otherwise go to IDLE.
REQ-020 SHALL, in COMMIT, write data to the addressed register for one cycle and then return to IDLE.
REQ-021 SHALL make a committed write visible on outputs no later than the 4th clk rising edge after ncs rises at the pin.
REQ-022 SHALL discard frames of fewer or more than 16 bits and writes to addresses 0x05-0x7F with no register change.
REQ-023 SHALL ignore an ncs falling edge seen during COMMIT; the next frame requires a fresh ncs falling edge.
REQ-024 SHALL hold all register outputs stable except during a COMMIT write.
REQ-025 SHALL operate correctly with sclk frequency <= clk/8.

Reset
REQ-026 SHALL, while rst is high, clear all five registers to 0x00, set the FSM to IDLE and clear the counter and shift register.
REQ-027 SHALL, on rst, reset synchronizers to idle levels (ncs=1, sclk=0, copi=0) and drive cipo=0.
REQ-028 SHALL, on rst asserted mid-frame, abort the frame without any register write; after release, wait for a new ncs falling edge.

Configuration
REQ-029 SHALL support macro SPI_READBACK_EN; when defined, read frames are served on cipo.
REQ-030 SHALL, with SPI_READBACK_EN, after the 8th sclk rising edge of a read frame, drive the addressed register MSB first on cipo, updating on each sclk falling edge for bits 7..0.
REQ-031 SHALL, with SPI_READBACK_EN, return 0x00 on reads of addresses >0x04.
REQ-032 SHALL, with SPI_READBACK_EN, drive cipo=0 whenever ncs is high.
REQ-033 SHALL, without SPI_READBACK_EN, tie cipo to 0 and leave read frames with no effect.

Verification
REQ-034 SHALL verify: frame 0x80F0 -> en_reg_out_7_0=0xF0 within 4 clk after ncs rises; other registers remain 0x00.
REQ-035 SHALL verify: frame 0x8480 -> pwm_duty_cycle=0x80; then frame 0x83FF -> en_reg_pwm_15_8=0xFF with pwm_duty_cycle still 0x80.
REQ-036 SHALL verify: frame 0xB0AA (address 0x30) and read frame 0x00AA -> no register changes.
REQ-037 SHALL verify: 12-bit frame 0x80F and 17-bit frame 0x1_80F0 -> no register changes; a following 0x8155 -> en_reg_out_15_8=0x55.
REQ-038 SHALL verify: rst pulsed after 8 bits of 0x82AA -> all outputs 0x00, no write; a following full 0x82AA -> en_reg_pwm_7_0=0xAA.
REQ-039 SHALL verify, with SPI_READBACK_EN: write 0x845A then read frame 0x0400 -> cipo bits 7..0 = 0x5A; without the macro, cipo stays 0.
